i2s_tdm_core: RTL and testbench



---
 rtl/i2s_pkg.sv | 23 ++
 rtl/i2s_tdm_core_if.sv | 25 ++
 rtl/i2s_clk_gen.sv | 54 +++++
 rtl/i2s_tdm_core.sv | 100 ++++++++++
 tb/tb_i2s_tdm_core.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/i2s_pkg.sv
// Shared I2S/TDM definitions: format encodings, latched per-frame config, parameter legality checks.
// Pure declarations, no logic.
package i2s_pkg;

    localparam logic FMT_I2S = 1'b0;
    localparam logic FMT_LJ  = 1'b1;

    typedef struct packed {
        logic fmt;
        logic mute;
        logic loopback;
    } cfg_t;

    function automatic bit clk_params_ok(input int mclk_sclk, input int sclk_ws);
        return (mclk_sclk >= 2) && (mclk_sclk % 2 == 0) && (sclk_ws >= 2);
    endfunction

    function automatic bit frame_params_ok(input int sclk_ws, input int d_width, input int channels);
        return (channels >= 2) && (channels % 2 == 0) && (sclk_ws % channels == 0) &&
               (d_width >= 1) && (d_width <= sclk_ws / channels - 1);
    endfunction

endpackage

// File: rtl/i2s_tdm_core_if.sv
// Parallel sample side and serial pin side of the I2S/TDM core.
// master = core, slave = sample producer/consumer and serial peer.
interface i2s_tdm_core_if #(
    parameter int CHANNELS = 2,
    parameter int D_WIDTH  = 24
);
    logic                          sclk;
    logic                          ws;
    logic                          sd_tx;
    logic                          sd_rx;
    logic [CHANNELS*D_WIDTH-1:0]   tx_data;
    logic                          tx_load;
    logic [CHANNELS*D_WIDTH-1:0]   rx_data;
    logic                          rx_valid;

    modport master (
        output sclk, ws, sd_tx, tx_load, rx_data, rx_valid,
        input  sd_rx, tx_data
    );

    modport slave (
        input  sclk, ws, sd_tx, tx_load, rx_data, rx_valid,
        output sd_rx, tx_data
    );
endinterface

// File: rtl/i2s_clk_gen.sv
// Bit/frame timing: sclk from mclk divider, ws, bit counter, rise/fall/frame strobes (strobe = edge happens at this clk).
// Latency: strobes combinational from div; sclk/ws/bit_cnt registered. No backpressure: free-running.
module i2s_clk_gen
    import i2s_pkg::*;
#(
    parameter  int MCLK_SCLK_RATIO = 4,
    parameter  int SCLK_WS_RATIO   = 64,
    localparam int BW              = $clog2(SCLK_WS_RATIO)
) (
    input  logic          clk,
    input  logic          reset,
    output logic          sclk,
    output logic          ws,
    output logic          rise_stb,
    output logic          fall_stb,
    output logic          frame_stb,
    output logic [BW-1:0] bit_cnt,
    output logic [BW-1:0] bit_nxt
);
    localparam int             DVW      = $clog2(MCLK_SCLK_RATIO);
    localparam logic [DVW-1:0] DIV_LAST = DVW'(MCLK_SCLK_RATIO - 1);
    localparam logic [DVW-1:0] DIV_RISE = DVW'(MCLK_SCLK_RATIO / 2 - 1);
    localparam logic [BW-1:0]  BIT_LAST = BW'(SCLK_WS_RATIO - 1);
    localparam logic [BW-1:0]  BIT_HALF = BW'(SCLK_WS_RATIO / 2);

    if (!clk_params_ok(MCLK_SCLK_RATIO, SCLK_WS_RATIO)) begin : g_bad_clk_params
        $error("i2s_clk_gen: illegal MCLK_SCLK_RATIO/SCLK_WS_RATIO");
    end

    logic [DVW-1:0] div;

    assign rise_stb  = (div == DIV_RISE);
    assign fall_stb  = (div == DIV_LAST);
    assign frame_stb = fall_stb && (bit_cnt == BIT_LAST);
    assign bit_nxt   = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            div     <= '0;
            sclk    <= 1'b0;
            ws      <= 1'b0;
            bit_cnt <= '0;
        end else begin
            div <= fall_stb ? '0 : div + 1'b1;
            if (rise_stb)
                sclk <= 1'b1;
            if (fall_stb) begin
                sclk    <= 1'b0;
                bit_cnt <= bit_nxt;
                ws      <= (bit_nxt >= BIT_HALF);
            end
        end
    end
endmodule

// File: rtl/i2s_tdm_core.sv
// I2S/TDM master: shadows tx_data per frame and serialises it; deserialises sd_rx (or sd_tx in loopback) into rx_data.
// Latency: sample latched at boundary N goes out in frame N+1, rx shown at frame end. No backpressure: tx_load/rx_valid are pulses.
module i2s_tdm_core
    import i2s_pkg::*;
#(
    parameter int MCLK_SCLK_RATIO = 4,
    parameter int SCLK_WS_RATIO   = 64,
    parameter int D_WIDTH         = 24,
    parameter int CHANNELS        = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           fmt,
    input  logic           mute,
    input  logic           loopback,
    i2s_tdm_core_if.master bus
);
    localparam int SLOT_W = SCLK_WS_RATIO / CHANNELS;
    localparam int BW     = $clog2(SCLK_WS_RATIO);
    localparam int DW_ALL = CHANNELS * D_WIDTH;
    localparam int IW     = $clog2(DW_ALL);

    if (!frame_params_ok(SCLK_WS_RATIO, D_WIDTH, CHANNELS)) begin : g_bad_frame_params
        $error("i2s_tdm_core: illegal CHANNELS/D_WIDTH/SCLK_WS_RATIO");
    end

    logic              sclk, ws, rise_stb, fall_stb, frame_stb;
    logic [BW-1:0]     bit_cnt, bit_nxt;
    cfg_t              cfg_q, cfg_nxt;
    logic [DW_ALL-1:0] tx_shadow, tx_nxt, rx_shadow, rx_data_q;
    logic              sd_tx_q, tx_bit, rx_in, boundary_q;
    int                tx_pos, rx_pos;

    i2s_clk_gen #(
        .MCLK_SCLK_RATIO (MCLK_SCLK_RATIO),
        .SCLK_WS_RATIO   (SCLK_WS_RATIO)
    ) u_clk_gen (
        .clk       (clk),
        .reset     (reset),
        .sclk      (sclk),
        .ws        (ws),
        .rise_stb  (rise_stb),
        .fall_stb  (fall_stb),
        .frame_stb (frame_stb),
        .bit_cnt   (bit_cnt),
        .bit_nxt   (bit_nxt)
    );

    // Flat rx/tx vector index carried by serial bit b, or -1 for padding positions.
    function automatic int slot_pos(input int b, input logic f);
        int bit_idx;
        bit_idx = (b % SLOT_W) - ((f == FMT_I2S) ? 1 : 0);
        if (bit_idx < 0 || bit_idx >= D_WIDTH)
            return -1;
        return (b / SLOT_W) * D_WIDTH + (D_WIDTH - 1 - bit_idx);
    endfunction

    // The first bit of a frame must already see the config and samples latched at that same boundary.
    always_comb begin
        cfg_nxt = cfg_q;
        tx_nxt  = tx_shadow;
        if (frame_stb) begin
            cfg_nxt = '{fmt, mute, loopback};
            tx_nxt  = bus.tx_data;
        end
        tx_pos = slot_pos(int'(bit_nxt), cfg_nxt.fmt);
        tx_bit = (tx_pos >= 0) && !cfg_nxt.mute && tx_nxt[IW'(tx_pos)];
        rx_pos = slot_pos(int'(bit_cnt), cfg_q.fmt);
        rx_in  = cfg_q.loopback ? sd_tx_q : bus.sd_rx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_q      <= '0;
            tx_shadow  <= '0;
            rx_shadow  <= '0;
            rx_data_q  <= '0;
            sd_tx_q    <= 1'b0;
            boundary_q <= 1'b0;
        end else begin
            boundary_q <= frame_stb;
            if (fall_stb)
                sd_tx_q <= tx_bit;
            if (frame_stb) begin
                cfg_q     <= cfg_nxt;
                tx_shadow <= tx_nxt;
                rx_data_q <= rx_shadow;
            end
            if (rise_stb && rx_pos >= 0)
                rx_shadow[IW'(rx_pos)] <= rx_in;
        end
    end

    assign bus.sclk     = sclk;
    assign bus.ws       = ws;
    assign bus.sd_tx    = sd_tx_q;
    assign bus.tx_load  = boundary_q;
    assign bus.rx_valid = boundary_q;
    assign bus.rx_data  = rx_data_q;
endmodule

// File: tb/tb_i2s_tdm_core.sv
// Scoreboarded bench for i2s_tdm_core: 2-channel default instance plus a 4-slot TDM instance.
module tb_i2s_tdm_core;
    import i2s_pkg::*;

    localparam int DW   = 24;
    localparam int SLOT = 32;
    localparam logic [47:0] X0  = {24'h13579B, 24'h2468AC};
    localparam logic [47:0] E0  = {24'hC0FFEE, 24'h0BEEF1};
    localparam logic [47:0] X1  = {24'h5A5A5A, 24'hA5A5A5};
    localparam logic [47:0] X2  = {24'h123456, 24'hFEDCBA};
    localparam logic [47:0] X3  = {24'h0F0F0F, 24'h800001};
    localparam logic [47:0] X4  = {24'h3C3C3C, 24'hC3C3C3};
    localparam logic [47:0] EXT = {24'h800001, 24'h7FFFFE};
    localparam logic [47:0] JNK = 48'hFFFF_FFFF_FFFF;
    localparam logic [95:0] TBD = {24'h444444, 24'h333333, 24'h222222, 24'h111111};

    typedef struct {
        logic [127:0] data;
        int           cyc;
    } sb_t;

    logic clk = 1'b0;
    logic reset_a, reset_b, fmt_a, mute_a, lb_a, fmt_b, mute_b, lb_b;
    int   rc = 0;
    bit   run_a = 1'b0, run_b = 1'b0;
    int   n_cmp = 0, n_bad = 0;
    sb_t  sb_a[$], sb_b[$];

    i2s_tdm_core_if #(.CHANNELS(2), .D_WIDTH(24)) bus_a ();
    i2s_tdm_core_if #(.CHANNELS(4), .D_WIDTH(24)) bus_b ();

    i2s_tdm_core #(.MCLK_SCLK_RATIO(4), .SCLK_WS_RATIO(64), .D_WIDTH(24), .CHANNELS(2)) dut_a (
        .clk(clk), .reset(reset_a), .fmt(fmt_a), .mute(mute_a), .loopback(lb_a), .bus(bus_a)
    );

    i2s_tdm_core #(.MCLK_SCLK_RATIO(4), .SCLK_WS_RATIO(128), .D_WIDTH(24), .CHANNELS(4)) dut_b (
        .clk(clk), .reset(reset_b), .fmt(fmt_b), .mute(mute_b), .loopback(lb_b), .bus(bus_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (rc=%0d)", tag, obs, exp, rc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        rc++;
    endtask

    // Serial bit b of a frame carrying d; padding positions return fill.
    function automatic logic model_bit(input logic [127:0] d, input logic fm, input int b, input logic fill);
        int k, o, idx;
        logic [127:0] v;
        k   = b / SLOT;
        o   = b % SLOT;
        idx = DW - 1 - o + ((fm == FMT_I2S) ? 1 : 0);
        if (idx < 0 || idx >= DW)
            return fill;
        v = d;
        return v[7'(k * DW + idx)];
    endfunction

    task automatic chk_idle_a(input string t);
        chk({t, "_sclk"}, bus_a.sclk, 1'b0);
        chk({t, "_ws"}, bus_a.ws, 1'b0);
        chk({t, "_sd_tx"}, bus_a.sd_tx, 1'b0);
        chk({t, "_tx_load"}, bus_a.tx_load, 1'b0);
        chk({t, "_rx_valid"}, bus_a.rx_valid, 1'b0);
        chk({t, "_rx_data"}, bus_a.rx_data, 48'h0);
    endtask

    task automatic push_a(input logic [47:0] d, input int c);
        sb_t e;
        e.data = 128'(d);
        e.cyc  = c;
        sb_a.push_back(e);
    endtask

    task automatic push_b(input logic [95:0] d, input int c);
        sb_t e;
        e.data = 128'(d);
        e.cyc  = c;
        sb_b.push_back(e);
    endtask

    // One full frame of DUT A: checks sclk/ws/sd_tx, drives sd_rx, applies mid-frame input changes at bit 36.
    task automatic run_frame_a(input logic [47:0] txd, input logic fm, input logic mu, input logic [47:0] rxe,
                               input logic nfm, input logic nmu, input logic nlb, input logic [47:0] ntx);
        for (int b = 0; b < 64; b++) begin
            for (int p = 0; p < 4; p++) begin
                if (p == 0) begin
                    bus_a.sd_rx = model_bit(128'(rxe), fm, b, 1'b1);
                    chk("a_sclk_lo", bus_a.sclk, 1'b0);
                    if (b == 36) begin
                        fmt_a = nfm;
                        mute_a = nmu;
                        lb_a = nlb;
                        bus_a.tx_data = ntx;
                    end
                end
                if (p == 1) begin
                    chk("a_sd_tx", bus_a.sd_tx, mu ? 1'b0 : model_bit(128'(txd), fm, b, 1'b0));
                    chk("a_ws", bus_a.ws, b >= 32);
                end
                if (p == 2)
                    chk("a_sclk_hi", bus_a.sclk, 1'b1);
                tick();
            end
        end
    endtask

    always @(negedge clk) begin : mon_a
        sb_t e;
        logic exp_p;
        exp_p = run_a && rc > 0 && (rc % 256) == 0;
        chk("a_rx_valid", bus_a.rx_valid, exp_p);
        chk("a_tx_load", bus_a.tx_load, exp_p);
        if (bus_a.rx_valid) begin
            chk("a_sb_depth", sb_a.size() > 0, 1'b1);
            if (sb_a.size() > 0) begin
                e = sb_a.pop_front();
                chk("a_rx_data", bus_a.rx_data, e.data);
                chk("a_rx_cycle", rc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        sb_t e;
        logic exp_p;
        exp_p = run_b && rc > 0 && (rc % 512) == 0;
        chk("b_rx_valid", bus_b.rx_valid, exp_p);
        if (bus_b.rx_valid) begin
            chk("b_sb_depth", sb_b.size() > 0, 1'b1);
            if (sb_b.size() > 0) begin
                e = sb_b.pop_front();
                chk("b_rx_data", bus_b.rx_data, e.data);
                chk("b_rx_cycle", rc, e.cyc);
            end
        end
    end

    initial begin
        reset_a = 1'b1; reset_b = 1'b1;
        fmt_a = FMT_I2S; mute_a = 1'b0; lb_a = 1'b0;
        fmt_b = FMT_I2S; mute_b = 1'b0; lb_b = 1'b0;
        bus_a.tx_data = X0; bus_a.sd_rx = 1'b0;
        bus_b.tx_data = '0; bus_b.sd_rx = 1'b0;
        repeat (3) tick();
        chk_idle_a("rst");
        chk("rst_b_ws", bus_b.ws, 1'b0);
        chk("rst_b_rx_data", bus_b.rx_data, 96'h0);

        // Frame 0 from external sd_rx, then reset 300 cycles in: aborts frame 1, clears everything.
        reset_a = 1'b0; rc = 0; run_a = 1'b1;
        push_a(E0, 256);
        run_frame_a(48'h0, FMT_I2S, 1'b0, E0, FMT_I2S, 1'b0, 1'b0, X0);
        repeat (44) tick();
        reset_a = 1'b1; run_a = 1'b0;
        lb_a = 1'b1; fmt_a = FMT_I2S; mute_a = 1'b0; bus_a.tx_data = X1;
        repeat (3) tick();
        chk_idle_a("midrst");

        reset_a = 1'b0; rc = 0; run_a = 1'b1;
        push_a(48'h0, 256);
        push_a(X1, 512);
        push_a(X2, 768);
        push_a(48'h0, 1024);
        push_a(EXT, 1280);
        run_frame_a(48'h0, FMT_I2S, 1'b0, 48'h0, FMT_I2S, 1'b0, 1'b1, X1);
        run_frame_a(X1, FMT_I2S, 1'b0, JNK, FMT_LJ, 1'b0, 1'b1, X2);
        run_frame_a(X2, FMT_LJ, 1'b0, JNK, FMT_LJ, 1'b1, 1'b1, X3);
        run_frame_a(X3, FMT_LJ, 1'b1, JNK, FMT_I2S, 1'b0, 1'b0, X4);
        run_frame_a(X4, FMT_I2S, 1'b0, EXT, FMT_I2S, 1'b0, 1'b0, X4);
        repeat (2) tick();
        reset_a = 1'b1; run_a = 1'b0;

        // 4-slot TDM instance in loopback.
        lb_b = 1'b1; bus_b.tx_data = TBD;
        tick();
        reset_b = 1'b0; rc = 0; run_b = 1'b1;
        push_b(96'h0, 512);
        push_b(TBD, 1024);
        push_b(TBD, 1536);
        for (int i = 0; i < 1540; i++) begin
            chk("b_ws", bus_b.ws, (rc % 512) >= 256);
            if (rc % 4 == 1)
                chk("b_sd_tx", bus_b.sd_tx,
                    model_bit((rc < 512) ? 128'h0 : 128'(TBD), FMT_I2S, (rc % 512) / 4, 1'b0));
            tick();
        end
        chk("a_sb_left", sb_a.size(), 0);
        chk("b_sb_left", sb_b.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
